// File: rtl/time_keeper_if.sv
// Connection between the time-of-day counter and its neighbours:
// raw switch/buttons in, current time and status out.
interface time_keeper_if;
  logic       set_sw;
  logic [3:0] btn;
  logic [5:0] c_hour;
  logic [5:0] c_min;
  logic [5:0] c_sec;
  logic       sec_tick;
  logic       set_mode;

  modport master (
    output set_sw, btn,
    input  c_hour, c_min, c_sec, sec_tick, set_mode
  );

  modport slave (
    input  set_sw, btn,
    output c_hour, c_min, c_sec, sec_tick, set_mode
  );
endinterface

// File: rtl/time_keeper.sv
// 24-hour time-of-day counter: divides clk to a one-second tick and lets the
// user adjust hours/minutes and clear seconds while the set switch is on.
module time_keeper #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic          clk,
  input  logic          rst,
  time_keeper_if.slave  bus_io
);

  localparam int            PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PS_ONE = PW'(1);

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } mode_e;

  mode_e         state_q, state_d;
  logic          set_s1_q, set_s2_q;
  logic [2:0]    btn_s1_q, btn_s2_q, btn_prev_q;
  logic [PW-1:0] ps_q, ps_d;
  logic [5:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          tick_q, tick_d;
  logic          set_mode_q, set_mode_d;
  logic [2:0]    btn_raw_s;
  logic [2:0]    btn_pulse_s;
  logic          unused_btn_s;

  // Only hour+, minute+ and clear are used; bit 2 belongs to the alarm view.
  assign btn_raw_s    = {bus_io.btn[3], bus_io.btn[1], bus_io.btn[0]};
  assign unused_btn_s = bus_io.btn[2];
  assign btn_pulse_s  = btn_s2_q & ~btn_prev_q;

  // Two-flop synchronizers and rising-edge history for switch and buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_s1_q   <= 1'b0;
      set_s2_q   <= 1'b0;
      btn_s1_q   <= 3'b000;
      btn_s2_q   <= 3'b000;
      btn_prev_q <= 3'b000;
    end else begin
      set_s1_q   <= bus_io.set_sw;
      set_s2_q   <= set_s1_q;
      btn_s1_q   <= btn_raw_s;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  // Mode state follows the synchronized switch; set_mode mirrors it
  always_comb begin
    state_d    = state_q;
    set_mode_d = 1'b0;
    case (set_s2_q)
      1'b1:    state_d = ST_SET;
      1'b0:    state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    if (state_d == ST_SET) begin
      set_mode_d = 1'b1;
    end else begin
      set_mode_d = 1'b0;
    end
  end

  // Prescaler, seconds carry chain and set-mode adjustments
  always_comb begin
    ps_d   = ps_q;
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    tick_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A set-mode entry on the wrap edge suppresses the tick.
        if (set_s2_q) begin
          ps_d = '0;
        end else if (ps_q >= PS_MAX) begin
          ps_d   = '0;
          tick_d = 1'b1;
        end else begin
          ps_d = ps_q + PS_ONE;
        end

        if (tick_d) begin
          if (sec_q >= 6'd59) begin
            sec_d = 6'd0;
            if (min_q >= 6'd59) begin
              min_d  = 6'd0;
              hour_d = (hour_q >= 6'd23) ? 6'd0 : hour_q + 6'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          sec_d = sec_q;
        end
      end
      ST_SET: begin
        ps_d = '0;
        if (btn_pulse_s[0]) begin
          hour_d = (hour_q >= 6'd23) ? 6'd0 : hour_q + 6'd1;
        end else begin
          hour_d = hour_q;
        end
        if (btn_pulse_s[1]) begin
          min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
        end else begin
          min_d = min_q;
        end
        if (btn_pulse_s[2]) begin
          sec_d = 6'd0;
        end else begin
          sec_d = sec_q;
        end
      end
      default: begin
        ps_d = '0;
      end
    endcase
  end

  // Mode state, prescaler and time-of-day registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      set_mode_q <= 1'b0;
      ps_q       <= '0;
      hour_q     <= 6'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_mode_q <= set_mode_d;
      ps_q       <= ps_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      tick_q     <= tick_d;
    end
  end

  assign bus_io.c_hour   = hour_q;
  assign bus_io.c_min    = min_q;
  assign bus_io.c_sec    = sec_q;
  assign bus_io.sec_tick = tick_q;
  assign bus_io.set_mode = set_mode_q;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: directed scenarios plus random button
// and switch activity, compared every cycle against a seconds-of-day model.
module tb_time_keeper;
  localparam int HZ = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   tick_cnt;

  // Reference state: time as seconds since midnight, cycles since run resumed
  int         m_tod;
  int         m_cnt;
  bit         m_mode;
  bit         m_tick;
  bit         sw_h  [4];
  logic [3:0] btn_h [4];

  time_keeper_if tk_if ();

  time_keeper #(.CLK_HZ(HZ)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (tk_if.slave)
  );

  always #5 clk = ~clk;

  function automatic int m_h(); return m_tod / 3600;       endfunction
  function automatic int m_m(); return (m_tod / 60) % 60;  endfunction
  function automatic int m_s(); return m_tod % 60;         endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tod  = 0;
    m_cnt  = 0;
    m_mode = 1'b0;
    m_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sw_h[i]  = 1'b0;
      btn_h[i] = 4'b0000;
    end
  endtask

  // Input seen at edge E changes set_mode at E+2; a press is applied at E+2
  // if the button was low at the previous sample.
  task automatic model_edge();
    int         h, m, s;
    logic [3:0] p;
    bit         new_mode;
    for (int i = 3; i > 0; i--) begin
      sw_h[i]  = sw_h[i-1];
      btn_h[i] = btn_h[i-1];
    end
    sw_h[0]  = tk_if.set_sw;
    btn_h[0] = tk_if.btn;
    new_mode = sw_h[2];
    m_tick   = 1'b0;
    if (m_mode || new_mode) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == HZ) begin
        m_cnt  = 0;
        m_tick = 1'b1;
        m_tod  = (m_tod + 1) % 86400;
      end
    end
    if (m_mode) begin
      p = btn_h[2] & ~btn_h[3];
      h = m_h(); m = m_m(); s = m_s();
      if (p[0]) h = (h + 1) % 24;
      if (p[1]) m = (m + 1) % 60;
      if (p[3]) s = 0;
      m_tod = h * 3600 + m * 60 + s;
    end
    m_mode = new_mode;
  endtask

  task automatic check_all();
    chk("hour",     tk_if.c_hour,   m_h());
    chk("min",      tk_if.c_min,    m_m());
    chk("sec",      tk_if.c_sec,    m_s());
    chk("sec_tick", tk_if.sec_tick, m_tick);
    chk("set_mode", tk_if.set_mode, m_mode);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic press(input logic [3:0] mask);
    tk_if.btn = mask;
    repeat (5) cyc();
    tk_if.btn = 4'b0000;
    repeat (3) cyc();
  endtask

  task automatic set_hm(input int th, input int tm);
    int n;
    n = (th - m_h() + 24) % 24;
    repeat (n) press(4'b0001);
    n = (tm - m_m() + 60) % 60;
    repeat (n) press(4'b0010);
  endtask

  initial begin
    tk_if.set_sw = 1'b0;
    tk_if.btn    = 4'b0000;
    model_reset();

    // Reset, then free-running count
    repeat (3) cyc();
    rst = 1'b0;
    tick_cnt = 0;
    for (int i = 1; i <= 25; i++) begin
      cyc();
      tick_cnt += int'(tk_if.sec_tick);
      if (i == 10) begin
        chk("sec_at_10",  tk_if.c_sec, 6'd1);
        chk("tick_at_10", tk_if.sec_tick, 1'b1);
      end
      if (i == 20) chk("sec_at_20", tk_if.c_sec, 6'd2);
    end
    chk("ticks_in_25", tick_cnt, 2);

    // Buttons ignored in run mode
    press(4'b0001);
    chk("run_lockout_hour", tk_if.c_hour, 6'd0);

    // set_mode latency
    tk_if.set_sw = 1'b1;
    cyc(); cyc();
    chk("mode_edge2", tk_if.set_mode, 1'b0);
    cyc();
    chk("mode_edge3", tk_if.set_mode, 1'b1);

    // Reach 05:30:17 and press three buttons together
    set_hm(5, 30);
    press(4'b1000);
    tk_if.set_sw = 1'b0;
    for (int k = 0; k < 400 && m_s() != 17; k++) cyc();
    tk_if.set_sw = 1'b1;
    repeat (4) cyc();
    chk("pre_simul_hour", tk_if.c_hour, 6'd5);
    chk("pre_simul_min",  tk_if.c_min,  6'd30);
    chk("pre_simul_sec",  tk_if.c_sec,  6'd17);
    tk_if.btn = 4'b1011;
    cyc(); cyc();
    chk("simul_edge2_hour", tk_if.c_hour, 6'd5);
    cyc();
    chk("simul_hour", tk_if.c_hour, 6'd6);
    chk("simul_min",  tk_if.c_min,  6'd31);
    chk("simul_sec",  tk_if.c_sec,  6'd0);
    repeat (2) cyc();
    tk_if.btn = 4'b0000;
    repeat (3) cyc();

    // Full wraps in set mode
    repeat (24) press(4'b0001);
    chk("wrap_hour",     tk_if.c_hour, 6'd6);
    chk("wrap_sec_frz",  tk_if.c_sec,  6'd0);
    repeat (60) press(4'b0010);
    chk("wrap_min",      tk_if.c_min,  6'd31);
    chk("wrap_min_hour", tk_if.c_hour, 6'd6);

    // Day rollover and first-tick latency after leaving set mode
    set_hm(23, 59);
    press(4'b1000);
    tk_if.set_sw = 1'b0;
    for (int k = 0; k < 700 && m_s() != 59; k++) cyc();
    chk("at_235959_sec", tk_if.c_sec, 6'd59);
    tk_if.set_sw = 1'b1;
    repeat (19) cyc();
    chk("frozen_sec",  tk_if.c_sec,  6'd59);
    chk("frozen_hour", tk_if.c_hour, 6'd23);
    tk_if.set_sw = 1'b0;
    for (int k = 0; k < 6 && tk_if.set_mode !== 1'b0; k++) cyc();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k < 10) chk("no_early_tick", tk_if.sec_tick, 1'b0);
    end
    chk("roll_tick", tk_if.sec_tick, 1'b1);
    chk("roll_hour", tk_if.c_hour,   6'd0);
    chk("roll_min",  tk_if.c_min,    6'd0);
    chk("roll_sec",  tk_if.c_sec,    6'd0);

    // Asynchronous reset at 12:34:56 with the prescaler at 7
    tk_if.set_sw = 1'b1;
    repeat (4) cyc();
    set_hm(12, 34);
    press(4'b1000);
    tk_if.set_sw = 1'b0;
    for (int k = 0; k < 700 && m_s() != 56; k++) cyc();
    repeat (7) cyc();
    chk("pre_rst_hour", tk_if.c_hour, 6'd12);
    chk("pre_rst_min",  tk_if.c_min,  6'd34);
    chk("pre_rst_sec",  tk_if.c_sec,  6'd56);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hour", tk_if.c_hour,   6'd0);
    chk("async_rst_min",  tk_if.c_min,    6'd0);
    chk("async_rst_sec",  tk_if.c_sec,    6'd0);
    chk("async_rst_tick", tk_if.sec_tick, 1'b0);
    model_reset();
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) cyc();
    chk("post_rst_tick", tk_if.sec_tick, 1'b1);
    chk("post_rst_sec",  tk_if.c_sec,    6'd1);

    // Random switch/button activity against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 3) tk_if.set_sw = ~tk_if.set_sw;
      tk_if.btn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
